// File: rtl/array_mult.sv
// array_mult: LANES independent pipelined 36x36 signed Q16 multipliers with rounding, saturation and sticky overflow.
module array_mult #(
    parameter int LANES   = 6,
    parameter int LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [LANES*36-1:0]   array_mult_dataa,
    input  logic [LANES*36-1:0]   array_mult_datab,
    input  logic                  valid_in,
    input  logic                  clear_ovf,
    output logic [LANES*36-1:0]   array_mult_result,
    output logic                  valid_out,
    output logic [LANES-1:0]      ovf
);
    logic        [35:0] a_q   [LANES];
    logic        [35:0] b_q   [LANES];
    logic signed [35:0] pp_hh [LANES];
    logic signed [36:0] pp_hl [LANES];
    logic signed [36:0] pp_lh [LANES];
    logic        [35:0] pp_ll [LANES];
    logic signed [71:0] p_q   [LANES];
    logic signed [71:0] p_sum [LANES];
    logic signed [71:0] r     [LANES];
    logic        [35:0] res_n [LANES];
    logic [LANES-1:0]   sat;
    logic [LATENCY-1:0] v_sr;

    assign valid_out = v_sr[LATENCY-1];

    // p_sum already carries the +2^15 rounding term, so stage 4 only shifts and clamps
    always_comb begin
        sat = '0;
        for (int k = 0; k < LANES; k++) begin
            p_sum[k] = (72'(pp_hh[k]) <<< 36) + (72'(pp_hl[k]) <<< 18) + (72'(pp_lh[k]) <<< 18)
                     + 72'(pp_ll[k]) + 72'(32768);
            r[k]     = p_q[k] >>> 16;
            sat[k]   = !((&r[k][71:35]) || !(|r[k][71:35]));
            res_n[k] = sat[k] ? (r[k][71] ? 36'h8_0000_0000 : 36'h7_FFFF_FFFF) : r[k][35:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                pp_hh[k] <= '0;
                pp_hl[k] <= '0;
                pp_lh[k] <= '0;
                pp_ll[k] <= '0;
                p_q[k]   <= '0;
            end
            array_mult_result <= '0;
            v_sr              <= '0;
            ovf               <= '0;
        end else if (en) begin
            for (int k = 0; k < LANES; k++) begin
                a_q[k]   <= array_mult_dataa[k*36 +: 36];
                b_q[k]   <= array_mult_datab[k*36 +: 36];
                pp_hh[k] <= 36'($signed(a_q[k][35:18])) * 36'($signed(b_q[k][35:18]));
                pp_hl[k] <= 37'($signed(a_q[k][35:18])) * 37'($signed({1'b0, b_q[k][17:0]}));
                pp_lh[k] <= 37'($signed({1'b0, a_q[k][17:0]})) * 37'($signed(b_q[k][35:18]));
                pp_ll[k] <= 36'(a_q[k][17:0]) * 36'(b_q[k][17:0]);
                p_q[k]   <= p_sum[k];
                array_mult_result[k*36 +: 36] <= res_n[k];
            end
            v_sr <= {v_sr[LATENCY-2:0], valid_in};
            // a saturation on the same edge as a clear leaves the flag set
            ovf  <= (clear_ovf ? '0 : ovf) | sat;
        end
    end
endmodule

// File: tb/tb_array_mult.sv
// tb_array_mult: directed checks of latency, rounding, saturation, stalls and async reset for array_mult.
module tb_array_mult;
    localparam int L = 6;
    localparam int W = L * 36;
    localparam logic [35:0] MAX = 36'h7_FFFF_FFFF;
    localparam logic [35:0] MIN = 36'h8_0000_0000;

    logic clk = 0, rst, en, valid_in, clear_ovf, valid_out;
    logic [W-1:0] da, db, res;
    logic [L-1:0] ovf;
    int errors = 0, checks = 0;
    logic [W-1:0] eq[$];
    logic vq[$];

    always #5 clk = ~clk;

    array_mult #(.LANES(L), .LATENCY(4)) dut (
        .clk(clk), .rst(rst), .en(en),
        .array_mult_dataa(da), .array_mult_datab(db),
        .valid_in(valid_in), .clear_ovf(clear_ovf),
        .array_mult_result(res), .valid_out(valid_out), .ovf(ovf)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero();
        da = '0;
        db = '0;
        valid_in = 0;
        clear_ovf = 0;
    endtask

    task automatic set_lane(input int k, input logic [35:0] a, input logic [35:0] b);
        da[k*36 +: 36] = a;
        db[k*36 +: 36] = b;
    endtask

    task automatic mul(input string tag, input int k, input logic [35:0] a, input logic [35:0] b,
                       input logic [35:0] exp);
        zero();
        set_lane(k, a, b);
        step();
        zero();
        step();
        step();
        step();
        check(tag, res[k*36 +: 36], exp);
    endtask

    task automatic cyc(input logic [W-1:0] ex, input string tag);
        logic [W-1:0] prev;
        logic pv;
        prev = res;
        pv = valid_out;
        step();
        if (en) begin
            eq.push_back(ex);
            vq.push_back(valid_in);
            check(tag, res, eq.pop_front());
            check({tag, "_valid"}, valid_out, vq.pop_front());
        end else begin
            check({tag, "_hold"}, res, prev);
            check({tag, "_vhold"}, valid_out, pv);
        end
    endtask

    initial begin
        logic [W-1:0] ex;
        logic [W-1:0] held;
        longint p;
        int s;
        rst = 1;
        en = 0;
        zero();
        #12;
        check("reset_res", res, '0);
        check("reset_valid", valid_out, 0);
        check("reset_ovf", ovf, '0);
        rst = 0;
        en = 1;
        set_lane(0, 36'd65536, 36'd65536);
        valid_in = 1;
        step();
        zero();
        check("lat_e1", res, '0);
        step();
        check("lat_e2", res, '0);
        step();
        check("lat_e3", res, '0);
        check("lat_v3", valid_out, 0);
        step();
        check("lat_e4", res, W'(36'd65536));
        check("lat_v4", valid_out, 1);
        step();
        check("lat_e5", res, '0);
        check("lat_v5", valid_out, 0);

        mul("rnd_half", 0, 36'd1, 36'd32768, 36'd1);
        mul("rnd_below", 0, 36'd1, 36'd32767, 36'd0);
        mul("rnd_neg_half", 0, 36'hF_FFFF_FFFF, 36'd32768, 36'd0);
        mul("rnd_neg", 0, 36'hF_FFFF_0000, 36'd32768, 36'hF_FFFF_8000);
        check("rnd_no_ovf", ovf, '0);

        mul("sat_pos", 0, MAX, MAX, MAX);
        check("sat_pos_ovf", ovf, 6'b000001);
        step();
        step();
        check("ovf_sticky", ovf, 6'b000001);
        mul("sat_neg", 1, MAX, MIN, MIN);
        check("sat_neg_ovf", ovf, 6'b000011);
        held = res;
        en = 0;
        clear_ovf = 1;
        step();
        clear_ovf = 0;
        en = 1;
        check("clr_frozen", ovf, 6'b000011);
        check("frozen_res", res, held);
        clear_ovf = 1;
        step();
        clear_ovf = 0;
        check("clr_ovf", ovf, '0);
        zero();
        set_lane(2, MAX, MAX);
        step();
        zero();
        step();
        step();
        clear_ovf = 1;
        step();
        clear_ovf = 0;
        check("clr_vs_sat_res", res[2*36 +: 36], MAX);
        check("clr_vs_sat_ovf", ovf, 6'b000100);
        clear_ovf = 1;
        step();
        clear_ovf = 0;
        check("clr_after", ovf, '0);

        zero();
        repeat (4) step();
        eq = {'0, '0, '0};
        vq = {1'b0, 1'b0, 1'b0};
        s = 0;
        for (int t = 0; t < 18; t++) begin
            en = !(t >= 4 && t < 7);
            zero();
            ex = '0;
            if (s < 10) begin
                valid_in = 1;
                for (int k = 0; k < L; k++) begin
                    p = longint'(k % 2 ? -(k + 1) : (k + 1)) * 65536;
                    set_lane(k, 36'((s + 1) * 65536), p[35:0]);
                    p = p * (s + 1);
                    ex[k*36 +: 36] = p[35:0];
                end
            end
            cyc(ex, "stream");
            if (en) s++;
        end

        for (int c = 0; c < 10; c++) begin
            zero();
            ex = '0;
            if (c < 6) begin
                p = longint'((c + 1) * 1000);
                set_lane(0, 36'd65536, p[35:0]);
                set_lane(1, 36'd0, p[35:0]);
                set_lane(2, 36'hF_FFFF_0000, p[35:0]);
                set_lane(3, 36'd32768, p[35:0]);
                ex[0 +: 36] = p[35:0];
                p = -p;
                ex[72 +: 36] = p[35:0];
                p = longint'((c + 1) * 500);
                ex[108 +: 36] = p[35:0];
            end
            cyc(ex, "window");
        end

        zero();
        set_lane(3, MAX, MAX);
        valid_in = 1;
        repeat (5) step();
        check("pre_rst_res", res[3*36 +: 36], MAX);
        check("pre_rst_ovf", ovf, 6'b001000);
        #3;
        rst = 1;
        #1;
        check("arst_res", res, '0);
        check("arst_valid", valid_out, 0);
        check("arst_ovf", ovf, '0);
        zero();
        #2;
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_res", res, '0);
            check("post_rst_valid", valid_out, 0);
        end
        check("post_rst_ovf", ovf, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/array_mult.md
# array_mult

Shared fixed-point multiplier array serving the transform-matrix builders in the full Jacobian datapath. It is the responder end of the array-multiplier interface: requesters drive `array_mult_dataa`/`array_mult_datab` each cycle, and the block returns `array_mult_result` a fixed number of enabled cycles later. Every lane is a pipelined 36-bit signed multiply in the datapath's fixed-point format (16 fractional bits, 65536 = 1.0), with rounding and saturation.

## Interface
Parameters:
- `LANES`, 6: number of independent multiplier lanes.
- `LATENCY`, 4: enabled clock edges from input sample to result; fixed at 4, other values unsupported.

Ports (modport `array_mult` of `ifc_array_mult`):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  pipeline advance; 0 freezes every stage.
- `array_mult_dataa`  in  LANES×36  signed operand A per lane.
- `array_mult_datab`  in  LANES×36  signed operand B per lane.
- `valid_in`  in  1  tag travelling with the operands; optional for requesters.
- `clear_ovf`  in  1  synchronous clear of sticky overflow flags.
- `array_mult_result`  out  LANES×36  rounded, saturated product per lane.
- `valid_out`  out  1  `valid_in` delayed by LATENCY enabled cycles.
- `ovf`  out  LANES  sticky per-lane saturation flag.

## Operation
- Per lane: P = A × B as full 72-bit signed product; R = (P + 2^15) >>> 16 (round half toward +∞); if R > 2^35−1 output 0x7_FFFF_FFFF, if R < −2^35 output 0x8_0000_0000, else R[35:0].
- Stage 1: register A, B, `valid_in`.
- Stage 2: four 18×18 partial products (A/B split into signed high 18 and unsigned low 18 bits), registered.
- Stage 3: sum partial products into 72-bit P, add rounding constant, registered.
- Stage 4: shift, saturate, register result; set `ovf[k]` when lane k saturates in this stage.
- `ovf[k]` stays 1 until `clear_ovf`; if `clear_ovf` and a new saturation coincide on the same enabled edge, the flag ends at 1 (set wins).
- `clear_ovf` acts only on enabled edges.
- Lanes are fully independent; no arbitration. Requesters that share the array time-multiplex by count windows and drive zeros outside their window; zero operands yield zero results.
- `valid_out` is informational only; the result is updated every enabled cycle regardless of the valid tag.

## Timing
- Reset (async assert, no clock needed): all pipeline registers, `array_mult_result`, `valid_out`, and `ovf` become 0 immediately. Outputs stay 0 until the first enabled edge after deassertion plus LATENCY.
- Latency: operands present before enabled edge N appear at `array_mult_result` after enabled edge N+3 (visible during cycle N+4, i.e. 4 enabled edges including the sampling edge). Throughput is one operand set per enabled cycle per lane.
- `en`=0: no register changes (including `ovf` and `clear_ovf` effects); outputs hold. Disabled cycles do not count toward latency.
- Reset mid-flight: all in-flight products are discarded; no stale result emerges after reset release.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Lane 0 A=65536, B=65536, en=1 -> result[0]=65536 exactly 4 enabled edges later, `valid_out` high in the same cycle as the result when `valid_in` was pulsed with the operands; earlier cycles show 0.
- Rounding: A=1,B=32768 -> 1; A=1,B=32767 -> 0; A=−1,B=32768 -> 0; A=−65536,B=32768 -> −32768 (0xF_FFFF_8000).
- Saturation: A=B=0x7_FFFF_FFFF -> 0x7_FFFF_FFFF and ovf[0]=1 persists; A=0x7_FFFF_FFFF,B=0x8_0000_0000 on lane 1 -> 0x8_0000_0000 and ovf[1]=1; `clear_ovf` with no new saturation -> ovf=0 on the next enabled edge; `clear_ovf` coinciding with a saturating result -> flag remains 1.
- Streaming all 6 lanes with distinct values each cycle, with `en` dropped low for 3 cycles mid-stream -> results match the golden model in order, with no skipped or duplicated results, and outputs are held during the stall.
- `rst` asserted asynchronously (between clock edges) with 4 products in flight -> outputs, `valid_out`, and `ovf` go 0 immediately; after release, zero operands give 0 results and no stale value appears.
- Back-to-back windowed use: 6 cycles of t-matrix style operands (e.g. cos θ=65536, sin α=0) followed by zero operands -> 6 correct results, then zeros.
